shell_cmd_engine: RTL and testbench
===================================

Name: shell_cmd_engine

Overview:
- Sits directly downstream of the bash I/O video-memory block and acts as its command consumer.
- Drains each entered command line from the line-out handshake into a local buffer and decodes a small built-in command set.
- Streams the response lines back through the line-in handshake.
- Holds the solved request until the video-memory acknowledges it, which returns the console to prompt mode.

Parameters:
BUF_LEN, 128, capture buffer depth in characters; longer lines are drained but truncated.
TOK_MAX, 16, maximum characters of the first token echoed back in the "not found" message.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous, active-low reset.
line_ready  input  1  video-memory out_newASCII_ready: a command line is available.
line_len  input  13  video-memory out_lineLen: character count, 0..128.
line_char  input  8  video-memory lineOut: current character; 0 once all characters are consumed.
line_next  output  1  one-cycle pulse to lineOut_nextASCII: current character taken.
resp_ready  output  1  to in_newASCII_ready: resp_char is valid.
resp_char  output  8  to lineIn: response character; 8'h00 terminates a line.
resp_next  input  1  from lineIn_nextASCII: one-cycle pulse, resp_char consumed.
solved  output  1  to in_solved: held high until solved_ack.
solved_ack  input  1  from out_solved.
cmd_code  output  3  last decoded command: 0 none, 1 empty, 2 hello, 3 echo, 4 help, 5 unknown.
busy  output  1  high in every state except IDLE.

Behaviour:
Reset (rst low, asynchronous):
- line_next=0, resp_ready=0, resp_char=0, solved=0, cmd_code=0, busy=0.
- State=IDLE; rx and tx indices cleared.
- Buffer contents are don't-care.

States:
- IDLE: line_ready=1 -> RX_SAMPLE, with rx_idx=0 and latched len=line_len.
- RX_SAMPLE:
  - rx_idx==len -> PARSE; no pulse is issued.
  - Otherwise: if rx_idx<BUF_LEN, store line_char at buf[rx_idx]. Pulse line_next for 1 cycle, rx_idx+1, -> RX_WAIT.
- RX_WAIT: one idle cycle, because the upstream index updates one cycle after the pulse. -> RX_SAMPLE.
- Capture rules:
  - Exactly len pulses are issued per line; none when len=0.
  - line_ready falling during RX aborts to PARSE with the characters captured so far.
- PARSE (1 cycle): eff_len=min(len,BUF_LEN); leading spaces are skipped. Decode:
  - eff_len=0 or all spaces -> empty, 0 lines.
  - token "hello" exact -> 1 line "Hello, World!".
  - token "echo" -> 1 line = buffer from first non-space after "echo " to eff_len-1. Bare "echo" gives an empty line (just 00).
  - token "help" -> 2 lines "Commands:" and "hello echo help".
  - Otherwise -> 1 line = first token truncated to TOK_MAX, then ": command not found".
  - Token matching is case-sensitive and terminated by a space or eff_len.
  - cmd_code updates at PARSE exit. Go to TX_LINE, or to SOLVE if there are 0 lines.
- TX_LINE: each line is segment A (buffer slice), then segment B (constant ROM string), then terminator 00. Either segment may be empty.
  - resp_ready=1 and resp_char = current character.
  - On resp_next: advance by exactly one character. The new character is valid the next cycle.
  - On resp_next while resp_char==00: resp_ready<=0 -> TX_GAP.
  - resp_char must not change while resp_ready=1 except in the cycle after resp_next.
- TX_GAP: resp_ready=0 for at least 1 cycle. More lines -> TX_LINE; else -> SOLVE.
- SOLVE: solved=1 and held. On solved_ack: solved<=0 -> IDLE.
  - Upstream ignores solved during scroll-clear, so solved is held indefinitely until acknowledged.
- A line_ready that rises again during TX or SOLVE is ignored until IDLE.
- resp_next outside TX_LINE is ignored. solved_ack outside SOLVE is ignored.
- Reset mid-transfer: outputs drop immediately; no partial pulse completes.

Test Plan:
- Line "hello" (len 5) -> exactly 5 line_next pulses, each separated by ≥1 low cycle. Response bytes 48 65 6C 6C 6F 2C 20 57 6F 72 6C 64 21 00. cmd_code=2. solved high until solved_ack, then IDLE.
- Line "echo  abc" (len 9) -> response 61 62 63 00, cmd_code=3. Bare "echo" (len 4) -> response 00 only.
- Empty line (len 0) -> no line_next, no resp_ready; solved asserted within 3 cycles of line_ready; cmd_code=1.
- Line "foobarbazquxquuxcorge x" -> response "foobarbazquxquux: command not found" followed by 00, token truncated at 16; cmd_code=5.
- Line "help" -> two 00-terminated lines, with resp_ready low ≥1 cycle between them. resp_next held off 5 cycles per character -> no character skipped or repeated.
- rst pulled low during TX_LINE of "hello" -> resp_ready=0 and solved=0 immediately. After release: IDLE, busy=0, and the next line processes normally.

Source files
------------

// File: rtl/shell_cmd_engine.sv
// shell_cmd_engine: command consumer for the bash I/O video-memory block.
// It drains one entered line into a local buffer, decodes a tiny built-in
// command set, streams the response lines back, then raises solved until
// the video-memory acknowledges it.
module shell_cmd_engine #(
    parameter int BUF_LEN = 128,
    parameter int TOK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_ready,
    input  logic [12:0] line_len,
    input  logic [7:0]  line_char,
    output logic        line_next,
    output logic        resp_ready,
    output logic [7:0]  resp_char,
    input  logic        resp_next,
    output logic        solved,
    input  logic        solved_ack,
    output logic [2:0]  cmd_code,
    output logic        busy
);

    // Buffer address width and a position width that can also hold BUF_LEN.
    localparam int AW = $clog2(BUF_LEN);
    localparam int PW = AW + 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RX_SAMPLE = 3'd1;
    localparam logic [2:0] ST_RX_WAIT   = 3'd2;
    localparam logic [2:0] ST_PARSE     = 3'd3;
    localparam logic [2:0] ST_TX_LINE   = 3'd4;
    localparam logic [2:0] ST_TX_GAP    = 3'd5;
    localparam logic [2:0] ST_SOLVE     = 3'd6;

    localparam logic [2:0] CMD_EMPTY   = 3'd1;
    localparam logic [2:0] CMD_HELLO   = 3'd2;
    localparam logic [2:0] CMD_ECHO    = 3'd3;
    localparam logic [2:0] CMD_HELP    = 3'd4;
    localparam logic [2:0] CMD_UNKNOWN = 3'd5;

    // A line is segment A (buffer slice), segment B (ROM slice), terminator.
    localparam logic [1:0] SEG_A = 2'd0;
    localparam logic [1:0] SEG_B = 2'd1;
    localparam logic [1:0] SEG_T = 2'd2;

    localparam logic [7:0] SPACE = 8'h20;

    // Constant response strings packed back to back; start/end are exclusive.
    localparam int ROM_LEN = 56;
    localparam logic [ROM_LEN*8-1:0] ROM_STR =
        {"Hello, World!", "Commands:", "hello echo help", ": command not found"};
    localparam logic [5:0] S0_START = 6'd0;
    localparam logic [5:0] S0_END   = 6'd13;
    localparam logic [5:0] S1_START = 6'd13;
    localparam logic [5:0] S1_END   = 6'd22;
    localparam logic [5:0] S2_START = 6'd22;
    localparam logic [5:0] S2_END   = 6'd37;
    localparam logic [5:0] S3_START = 6'd37;
    localparam logic [5:0] S3_END   = 6'd56;

    logic [2:0]    r_state;
    logic [12:0]   r_rx_idx;
    logic [12:0]   r_len;
    logic          r_line_next;
    logic          r_resp_ready;
    logic [7:0]    r_resp_char;
    logic          r_solved;
    logic [2:0]    r_cmd_code;
    logic          r_lines_left;
    logic [1:0]    r_seg;
    logic [PW-1:0] r_a_idx;
    logic [PW-1:0] r_a_end;
    logic [5:0]    r_r_idx;
    logic [5:0]    r_b_end;
    logic [7:0]    r_buf [0:BUF_LEN-1];

    logic          w_store;
    logic [PW-1:0] w_eff_len;
    logic [PW-1:0] w_s;
    logic          w_has_tok;
    logic [PW-1:0] w_e;
    logic [PW-1:0] w_arg;
    logic [PW-1:0] w_tok_len;
    logic [PW-1:0] w_tok_trunc;
    logic [7:0]    w_tc [0:4];
    logic          w_is_hello;
    logic          w_is_echo;
    logic          w_is_help;
    logic [2:0]    w_dec_code;
    logic [1:0]    w_dec_lines;
    logic [PW-1:0] w_dec_a_start;
    logic [PW-1:0] w_dec_a_end;
    logic [5:0]    w_dec_b_start;
    logic [5:0]    w_dec_b_end;
    logic [1:0]    w_cand_seg;
    logic [PW-1:0] w_cand_a;
    logic [5:0]    w_cand_r;
    logic [PW-1:0] w_end_a;
    logic [5:0]    w_end_r;
    logic [1:0]    w_nseg;
    logic [7:0]    w_nchar;
    logic [7:0]    w_rom [0:63];

    // Unpack the ROM string into a byte-addressable table, zero padded.
    for (genvar gi = 0; gi < 64; gi++) begin : g_rom
        if (gi < ROM_LEN) begin : g_used
            assign w_rom[gi] = ROM_STR[(ROM_LEN-1-gi)*8 +: 8];
        end else begin : g_pad
            assign w_rom[gi] = 8'h00;
        end
    end

    assign w_store = (r_state == ST_RX_SAMPLE) && (r_rx_idx != r_len) &&
                     line_ready && (r_rx_idx < 13'(BUF_LEN));

    // Capture buffer; characters beyond BUF_LEN are drained but dropped.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[AW'(r_rx_idx)] <= line_char;
        end
    end

    assign w_eff_len = (r_len > 13'(BUF_LEN)) ? PW'(BUF_LEN) : PW'(r_len);

    // Locate the first non-space character (token start).
    always_comb begin
        w_s       = w_eff_len;
        w_has_tok = 1'b0;
        for (int i = 0; i < BUF_LEN; i++) begin
            if (!w_has_tok && (PW'(i) < w_eff_len) && (r_buf[i] != SPACE)) begin
                w_s       = PW'(i);
                w_has_tok = 1'b1;
            end
        end
    end

    // Locate the token end: first space after the start, or eff_len.
    always_comb begin
        logic found;
        found = 1'b0;
        w_e   = w_eff_len;
        for (int i = 0; i < BUF_LEN; i++) begin
            if (!found && (PW'(i) >= w_s) && (PW'(i) < w_eff_len) && (r_buf[i] == SPACE)) begin
                w_e   = PW'(i);
                found = 1'b1;
            end
        end
    end

    // Locate the echo argument: first non-space after the token end.
    always_comb begin
        logic found;
        found = 1'b0;
        w_arg = w_eff_len;
        for (int i = 0; i < BUF_LEN; i++) begin
            if (!found && (PW'(i) >= w_e) && (PW'(i) < w_eff_len) && (r_buf[i] != SPACE)) begin
                w_arg = PW'(i);
                found = 1'b1;
            end
        end
    end

    // First five token characters, enough to match every built-in name.
    for (genvar gi = 0; gi < 5; gi++) begin : g_tok
        assign w_tc[gi] = r_buf[AW'(w_s + PW'(gi))];
    end

    assign w_tok_len   = w_e - w_s;
    assign w_tok_trunc = (w_tok_len > PW'(TOK_MAX)) ? PW'(TOK_MAX) : w_tok_len;
    assign w_is_hello  = (w_tok_len == PW'(5)) && (w_tc[0] == "h") && (w_tc[1] == "e") &&
                         (w_tc[2] == "l") && (w_tc[3] == "l") && (w_tc[4] == "o");
    assign w_is_echo   = (w_tok_len == PW'(4)) && (w_tc[0] == "e") && (w_tc[1] == "c") &&
                         (w_tc[2] == "h") && (w_tc[3] == "o");
    assign w_is_help   = (w_tok_len == PW'(4)) && (w_tc[0] == "h") && (w_tc[1] == "e") &&
                         (w_tc[2] == "l") && (w_tc[3] == "p");

    // Command decode: response line count and first-line segment bounds.
    always_comb begin
        w_dec_code    = CMD_UNKNOWN;
        w_dec_lines   = 2'd1;
        w_dec_a_start = w_s;
        w_dec_a_end   = w_s + w_tok_trunc;
        w_dec_b_start = S3_START;
        w_dec_b_end   = S3_END;
        if (!w_has_tok) begin
            w_dec_code    = CMD_EMPTY;
            w_dec_lines   = 2'd0;
            w_dec_a_start = '0;
            w_dec_a_end   = '0;
            w_dec_b_start = '0;
            w_dec_b_end   = '0;
        end else if (w_is_hello) begin
            w_dec_code    = CMD_HELLO;
            w_dec_a_start = '0;
            w_dec_a_end   = '0;
            w_dec_b_start = S0_START;
            w_dec_b_end   = S0_END;
        end else if (w_is_echo) begin
            w_dec_code    = CMD_ECHO;
            w_dec_a_start = w_arg;
            w_dec_a_end   = w_eff_len;
            w_dec_b_start = '0;
            w_dec_b_end   = '0;
        end else if (w_is_help) begin
            w_dec_code    = CMD_HELP;
            w_dec_lines   = 2'd2;
            w_dec_a_start = '0;
            w_dec_a_end   = '0;
            w_dec_b_start = S1_START;
            w_dec_b_end   = S1_END;
        end
    end

    // Next transmit position (line start or one step on), skipping empty
    // segments, and the character found there.
    always_comb begin
        w_cand_seg = SEG_A;
        w_cand_a   = r_a_idx;
        w_cand_r   = r_r_idx;
        w_end_a    = r_a_end;
        w_end_r    = r_b_end;
        case (r_state)
            ST_PARSE: begin
                w_cand_a = w_dec_a_start;
                w_cand_r = w_dec_b_start;
                w_end_a  = w_dec_a_end;
                w_end_r  = w_dec_b_end;
            end
            ST_TX_GAP: begin
                w_cand_a = '0;
                w_cand_r = S2_START;
                w_end_a  = '0;
                w_end_r  = S2_END;
            end
            default: begin
                w_cand_seg = r_seg;
                if (r_seg == SEG_A) begin
                    w_cand_a = r_a_idx + PW'(1);
                end else if (r_seg == SEG_B) begin
                    w_cand_r = r_r_idx + 6'd1;
                end
            end
        endcase
        w_nseg = w_cand_seg;
        if ((w_nseg == SEG_A) && (w_cand_a >= w_end_a)) begin
            w_nseg = SEG_B;
        end
        if ((w_nseg == SEG_B) && (w_cand_r >= w_end_r)) begin
            w_nseg = SEG_T;
        end
        case (w_nseg)
            SEG_A:   w_nchar = r_buf[AW'(w_cand_a)];
            SEG_B:   w_nchar = w_rom[w_cand_r];
            default: w_nchar = 8'h00;
        endcase
    end

    // Main control FSM: capture, decode, transmit, and solved handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_rx_idx     <= '0;
            r_len        <= '0;
            r_line_next  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_resp_char  <= 8'h00;
            r_solved     <= 1'b0;
            r_cmd_code   <= 3'd0;
            r_lines_left <= 1'b0;
            r_seg        <= SEG_A;
            r_a_idx      <= '0;
            r_a_end      <= '0;
            r_r_idx      <= '0;
            r_b_end      <= '0;
        end else begin
            r_line_next <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (line_ready) begin
                        r_rx_idx <= '0;
                        r_len    <= line_len;
                        r_state  <= ST_RX_SAMPLE;
                    end
                end
                ST_RX_SAMPLE: begin
                    if (r_rx_idx == r_len) begin
                        r_state <= ST_PARSE;
                    end else if (!line_ready) begin
                        r_len   <= r_rx_idx;
                        r_state <= ST_PARSE;
                    end else begin
                        r_line_next <= 1'b1;
                        r_rx_idx    <= r_rx_idx + 13'd1;
                        r_state     <= ST_RX_WAIT;
                    end
                end
                ST_RX_WAIT: begin
                    // Upstream advances its index one cycle after the pulse.
                    if (!line_ready) begin
                        r_len   <= r_rx_idx;
                        r_state <= ST_PARSE;
                    end else begin
                        r_state <= ST_RX_SAMPLE;
                    end
                end
                ST_PARSE: begin
                    r_cmd_code   <= w_dec_code;
                    r_lines_left <= (w_dec_lines == 2'd2);
                    if (w_dec_lines == 2'd0) begin
                        r_solved <= 1'b1;
                        r_state  <= ST_SOLVE;
                    end else begin
                        r_seg        <= w_nseg;
                        r_a_idx      <= w_cand_a;
                        r_r_idx      <= w_cand_r;
                        r_a_end      <= w_end_a;
                        r_b_end      <= w_end_r;
                        r_resp_char  <= w_nchar;
                        r_resp_ready <= 1'b1;
                        r_state      <= ST_TX_LINE;
                    end
                end
                ST_TX_LINE: begin
                    if (resp_next) begin
                        if (r_resp_char == 8'h00) begin
                            r_resp_ready <= 1'b0;
                            r_state      <= ST_TX_GAP;
                        end else begin
                            r_seg       <= w_nseg;
                            r_a_idx     <= w_cand_a;
                            r_r_idx     <= w_cand_r;
                            r_resp_char <= w_nchar;
                        end
                    end
                end
                ST_TX_GAP: begin
                    if (r_lines_left) begin
                        r_lines_left <= 1'b0;
                        r_seg        <= w_nseg;
                        r_a_idx      <= w_cand_a;
                        r_r_idx      <= w_cand_r;
                        r_a_end      <= w_end_a;
                        r_b_end      <= w_end_r;
                        r_resp_char  <= w_nchar;
                        r_resp_ready <= 1'b1;
                        r_state      <= ST_TX_LINE;
                    end else begin
                        r_solved <= 1'b1;
                        r_state  <= ST_SOLVE;
                    end
                end
                ST_SOLVE: begin
                    // Held indefinitely: upstream may ignore it while scrolling.
                    if (solved_ack) begin
                        r_solved <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign line_next  = r_line_next;
    assign resp_ready = r_resp_ready;
    assign resp_char  = r_resp_char;
    assign solved     = r_solved;
    assign cmd_code   = r_cmd_code;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_shell_cmd_engine.sv
// Directed bench for shell_cmd_engine with a small upstream line model.
module tb_shell_cmd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_ready;
    logic [12:0] line_len;
    logic [7:0]  line_char;
    logic        line_next;
    logic        resp_ready;
    logic [7:0]  resp_char;
    logic        resp_next;
    logic        solved;
    logic        solved_ack;
    logic [2:0]  cmd_code;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] line_mem [0:255];
    int         cur_len = 0;
    int         up_idx;
    logic       up_clr;
    int         pulse_cnt;
    int         adj_cnt;
    logic       prev_ln;
    logic       rr_seen;
    logic [7:0] resp_q [$];
    int         gap_min;
    int         stable_err;

    always #5 clk = ~clk;

    shell_cmd_engine #(.BUF_LEN(128), .TOK_MAX(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_ready (line_ready),
        .line_len   (line_len),
        .line_char  (line_char),
        .line_next  (line_next),
        .resp_ready (resp_ready),
        .resp_char  (resp_char),
        .resp_next  (resp_next),
        .solved     (solved),
        .solved_ack (solved_ack),
        .cmd_code   (cmd_code),
        .busy       (busy)
    );

    // Upstream: character index advances on the edge that sees line_next.
    assign line_char = (up_idx < cur_len) ? line_mem[up_idx] : 8'h00;

    always @(posedge clk) begin
        if (up_clr) begin
            up_idx    <= 0;
            pulse_cnt <= 0;
            adj_cnt   <= 0;
            prev_ln   <= 1'b0;
            rr_seen   <= 1'b0;
        end else begin
            if (line_next) begin
                up_idx    <= up_idx + 1;
                pulse_cnt <= pulse_cnt + 1;
                if (prev_ln) adj_cnt <= adj_cnt + 1;
            end
            prev_ln <= line_next;
            if (resp_ready) rr_seen <= 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vector %0d %s observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic send_line(input string s);
        cur_len = s.len();
        for (int i = 0; i < s.len(); i++) line_mem[i] = s[i];
        line_len = 13'(s.len());
        up_clr = 1'b1;
        tick();
        up_clr = 1'b0;
        line_ready = 1'b1;
    endtask

    task automatic get_lines(input int nlines, input int holdoff);
        int         wc;
        logic [7:0] c;
        bit         done;
        bit         first;
        resp_q.delete();
        gap_min = 1000;
        stable_err = 0;
        for (int l = 0; l < nlines; l++) begin
            done = 1'b0;
            first = 1'b1;
            while (!done) begin
                wc = 0;
                while (!resp_ready && wc < 200) begin
                    tick();
                    wc++;
                end
                if (!resp_ready) begin
                    check("resp_ready_timeout", resp_ready, 1);
                    return;
                end
                if (first && l > 0 && wc < gap_min) gap_min = wc;
                first = 1'b0;
                c = resp_char;
                for (int h = 0; h < holdoff; h++) begin
                    tick();
                    if (!resp_ready || resp_char !== c) stable_err++;
                end
                resp_next = 1'b1;
                tick();
                resp_next = 1'b0;
                resp_q.push_back(c);
                if (c == 8'h00) done = 1'b1;
            end
        end
    endtask

    // Expected text uses '|' for each 00 line terminator.
    task automatic check_resp(input string tag, input string exp);
        logic [31:0] obs;
        logic [31:0] e;
        check({tag, "_nbytes"}, resp_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            e   = (exp[i] == "|") ? 32'h0 : 32'(exp[i]);
            obs = (i < resp_q.size()) ? 32'(resp_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_byte%0d", tag, i), obs, e);
        end
    endtask

    task automatic finish_solve(input string tag, input logic [2:0] exp_code);
        int wc;
        wc = 0;
        while (!solved && wc < 50) begin
            tick();
            wc++;
        end
        check({tag, "_solved"}, solved, 1);
        line_ready = 1'b0;
        check({tag, "_cmd_code"}, cmd_code, exp_code);
        tick();
        tick();
        check({tag, "_solved_held"}, solved, 1);
        check({tag, "_busy_solve"}, busy, 1);
        solved_ack = 1'b1;
        tick();
        solved_ack = 1'b0;
        check({tag, "_solved_ack"}, solved, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int wc;
        rst        = 1'b0;
        line_ready = 1'b0;
        line_len   = '0;
        resp_next  = 1'b0;
        solved_ack = 1'b0;
        up_clr     = 1'b1;
        tick();
        tick();
        check("rst_line_next", line_next, 0);
        check("rst_resp_ready", resp_ready, 0);
        check("rst_resp_char", resp_char, 0);
        check("rst_solved", solved, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_busy", busy, 0);
        rst    = 1'b1;
        up_clr = 1'b0;
        tick();

        // hello
        send_line("hello");
        get_lines(1, 0);
        check("hello_pulses", pulse_cnt, 5);
        check("hello_adjacent_pulses", adj_cnt, 0);
        finish_solve("hello", 3'd2);
        check_resp("hello", "Hello, World!|");

        // echo with double space
        send_line("echo  abc");
        get_lines(1, 0);
        finish_solve("echo", 3'd3);
        check_resp("echo", "abc|");

        // bare echo
        send_line("echo");
        get_lines(1, 0);
        finish_solve("bare_echo", 3'd3);
        check_resp("bare_echo", "|");

        // empty line
        send_line("");
        wc = 0;
        while (!solved && wc < 10) begin
            tick();
            wc++;
        end
        check("empty_solved_latency_le3", (wc <= 3), 1);
        check("empty_pulses", pulse_cnt, 0);
        check("empty_no_resp_ready", rr_seen, 0);
        finish_solve("empty", 3'd1);

        // unknown command, token truncated to 16 characters
        send_line("foobarbazquxquuxcorge x");
        get_lines(1, 0);
        check("unknown_pulses", pulse_cnt, 23);
        finish_solve("unknown", 3'd5);
        check_resp("unknown", "foobarbazquxquux: command not found|");

        // help, slow consumer
        send_line("help");
        get_lines(2, 5);
        check("help_gap_ge1", (gap_min >= 1), 1);
        check("help_stable", stable_err, 0);
        finish_solve("help", 3'd4);
        check_resp("help", "Commands:|hello echo help|");

        // reset in the middle of a hello response
        send_line("hello");
        wc = 0;
        while (!resp_ready && wc < 200) begin
            tick();
            wc++;
        end
        check("mid_resp_ready_up", resp_ready, 1);
        for (int k = 0; k < 3; k++) begin
            resp_next = 1'b1;
            tick();
            resp_next = 1'b0;
        end
        check("mid_char_before_rst", resp_char, 8'h6C);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_resp_ready", resp_ready, 0);
        check("mid_rst_solved", solved, 0);
        check("mid_rst_busy", busy, 0);
        line_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_cmd_code", cmd_code, 0);

        send_line("hello");
        get_lines(1, 0);
        check("rehello_pulses", pulse_cnt, 5);
        finish_solve("rehello", 3'd2);
        check_resp("rehello", "Hello, World!|");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
